// File: rtl/ps2_key_decoder_if.sv
// ---------------------------------------------------------------------------
// ps2_key_decoder_if
//   Byte handshake between the PS/2 keyboard receiver FIFO and its consumer.
//
//   kbd_data        8  byte at the receiver FIFO head, valid while kbd_ready=1
//   kbd_ready       1  receiver FIFO non-empty
//   kbd_overflow    1  receiver FIFO overflow flag
//   kbd_nextdata_n  1  active-low pop strobe from the consumer
//
//   master : receiver side (drives data/ready/overflow, sees the pop strobe)
//   slave  : consumer side (the decoder)
// ---------------------------------------------------------------------------
interface ps2_key_decoder_if;
  logic [7:0] kbd_data;
  logic       kbd_ready;
  logic       kbd_overflow;
  logic       kbd_nextdata_n;

  modport master (
    output kbd_data,
    output kbd_ready,
    output kbd_overflow,
    input  kbd_nextdata_n
  );

  modport slave (
    input  kbd_data,
    input  kbd_ready,
    input  kbd_overflow,
    output kbd_nextdata_n
  );
endinterface

// File: rtl/ps2_key_decoder.sv
// ---------------------------------------------------------------------------
// ps2_key_decoder
//   Pops bytes from the PS/2 receiver FIFO and turns set-2 scancode streams
//   (make, F0 break, E0 extended) into single-cycle key events with ASCII,
//   press/release and typematic-repeat flags plus a distinct-press counter.
//
//   Parameters
//     ASCII_UPPER  1 = letters reported as uppercase ASCII, 0 = lowercase
//     CNT_W        width of press_count
//
//   Ports
//     clk          system clock, all logic on posedge
//     rst          asynchronous active-high reset
//     kbd          receiver handshake (slave modport): data/ready/overflow in,
//                  registered active-low pop strobe out
//     key_valid    one-cycle pulse, event fields below are new
//     key_code     scancode of the event, prefixes stripped
//     key_ext      event was E0-prefixed
//     key_release  1 = break, 0 = make
//     key_repeat   make is a typematic repeat of the held key
//     key_ascii    ASCII of key_code, 0x00 if unmapped or extended
//     key_held     a key is currently held (level)
//     press_count  count of distinct new presses, wraps
//     err_overflow sticky receiver overflow indication
// ---------------------------------------------------------------------------
module ps2_key_decoder #(
  parameter bit ASCII_UPPER = 1'b0,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  ps2_key_decoder_if.slave kbd,
  output logic             key_valid,
  output logic [7:0]       key_code,
  output logic             key_ext,
  output logic             key_release,
  output logic             key_repeat,
  output logic [7:0]       key_ascii,
  output logic             key_held,
  output logic [CNT_W-1:0] press_count,
  output logic             err_overflow
);

  // IDLE waits for a byte, ACK releases the pop strobe and decodes,
  // SETTLE gives the receiver a cycle to present its next head entry.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACK    = 2'd1,
    SETTLE = 2'd2
  } state_t;

  state_t             state_reg, state_next;
  logic [7:0]         byte_reg, byte_next;
  logic               nextdata_n_reg, nextdata_n_next;
  logic               ext_pend_reg, ext_pend_next;
  logic               brk_pend_reg, brk_pend_next;
  logic               valid_reg, valid_next;
  logic [7:0]         code_reg, code_next;
  logic               ext_reg, ext_next;
  logic               rel_reg, rel_next;
  logic               rpt_reg, rpt_next;
  logic [7:0]         ascii_reg, ascii_next;
  logic [8:0]         held_code_reg, held_code_next;  // {ext, code}
  logic               held_reg, held_next;
  logic [CNT_W-1:0]   count_reg, count_next;
  logic               err_reg, err_next;
  logic [8:0]         ev_id;

  // Set-2 scancode to ASCII for non-extended keys.
  function automatic logic [7:0] ascii_of(input logic [7:0] code);
    logic [7:0] a;
    case (code)
      8'h1C: a = 8'h61;  8'h32: a = 8'h62;  8'h21: a = 8'h63;
      8'h23: a = 8'h64;  8'h24: a = 8'h65;  8'h2B: a = 8'h66;
      8'h34: a = 8'h67;  8'h33: a = 8'h68;  8'h43: a = 8'h69;
      8'h3B: a = 8'h6A;  8'h42: a = 8'h6B;  8'h4B: a = 8'h6C;
      8'h3A: a = 8'h6D;  8'h31: a = 8'h6E;  8'h44: a = 8'h6F;
      8'h4D: a = 8'h70;  8'h15: a = 8'h71;  8'h2D: a = 8'h72;
      8'h1B: a = 8'h73;  8'h2C: a = 8'h74;  8'h3C: a = 8'h75;
      8'h2A: a = 8'h76;  8'h1D: a = 8'h77;  8'h22: a = 8'h78;
      8'h35: a = 8'h79;  8'h1A: a = 8'h7A;
      8'h45: a = 8'h30;  8'h16: a = 8'h31;  8'h1E: a = 8'h32;
      8'h26: a = 8'h33;  8'h25: a = 8'h34;  8'h2E: a = 8'h35;
      8'h36: a = 8'h36;  8'h3D: a = 8'h37;  8'h3E: a = 8'h38;
      8'h46: a = 8'h39;
      8'h29: a = 8'h20;  8'h5A: a = 8'h0D;  8'h66: a = 8'h08;
      default: a = 8'h00;
    endcase
    // Only the letter range is shifted; digits and controls are unaffected.
    if (ASCII_UPPER && (a >= 8'h61) && (a <= 8'h7A)) begin
      a = a - 8'h20;
    end
    return a;
  endfunction

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      byte_reg       <= 8'h00;
      nextdata_n_reg <= 1'b1;
      ext_pend_reg   <= 1'b0;
      brk_pend_reg   <= 1'b0;
      valid_reg      <= 1'b0;
      code_reg       <= 8'h00;
      ext_reg        <= 1'b0;
      rel_reg        <= 1'b0;
      rpt_reg        <= 1'b0;
      ascii_reg      <= 8'h00;
      held_code_reg  <= 9'h000;
      held_reg       <= 1'b0;
      count_reg      <= '0;
      err_reg        <= 1'b0;
    end else begin
      state_reg      <= state_next;
      byte_reg       <= byte_next;
      nextdata_n_reg <= nextdata_n_next;
      ext_pend_reg   <= ext_pend_next;
      brk_pend_reg   <= brk_pend_next;
      valid_reg      <= valid_next;
      code_reg       <= code_next;
      ext_reg        <= ext_next;
      rel_reg        <= rel_next;
      rpt_reg        <= rpt_next;
      ascii_reg      <= ascii_next;
      held_code_reg  <= held_code_next;
      held_reg       <= held_next;
      count_reg      <= count_next;
      err_reg        <= err_next;
    end
  end

  // Next-state and decode
  always_comb begin
    state_next      = state_reg;
    byte_next       = byte_reg;
    nextdata_n_next = 1'b1;
    ext_pend_next   = ext_pend_reg;
    brk_pend_next   = brk_pend_reg;
    valid_next      = 1'b0;
    code_next       = code_reg;
    ext_next        = ext_reg;
    rel_next        = rel_reg;
    rpt_next        = rpt_reg;
    ascii_next      = ascii_reg;
    held_code_next  = held_code_reg;
    held_next       = held_reg;
    count_next      = count_reg;
    err_next        = err_reg | kbd.kbd_overflow;
    ev_id           = {ext_pend_reg, byte_reg};

    case (state_reg)
      IDLE: begin
        if (kbd.kbd_ready) begin
          byte_next       = kbd.kbd_data;
          nextdata_n_next = 1'b0;
          state_next      = ACK;
        end
      end

      ACK: begin
        state_next = SETTLE;
        case (byte_reg)
          8'hE0: ext_pend_next = 1'b1;
          8'hF0: brk_pend_next = 1'b1;
          default: begin
            valid_next    = 1'b1;
            code_next     = byte_reg;
            ext_next      = ext_pend_reg;
            ascii_next    = ext_pend_reg ? 8'h00 : ascii_of(byte_reg);
            ext_pend_next = 1'b0;
            brk_pend_next = 1'b0;
            if (brk_pend_reg) begin
              rel_next = 1'b1;
              rpt_next = 1'b0;
              // Releasing some other key (rollover) keeps the held key.
              if (ev_id == held_code_reg) begin
                held_next = 1'b0;
              end
            end else begin
              rel_next = 1'b0;
              if (held_reg && (ev_id == held_code_reg)) begin
                rpt_next = 1'b1;
              end else begin
                rpt_next       = 1'b0;
                held_code_next = ev_id;
                held_next      = 1'b1;
                count_next     = count_reg + CNT_W'(1);
              end
            end
          end
        endcase
      end

      SETTLE: state_next = IDLE;

      default: state_next = IDLE;
    endcase
  end

  assign kbd.kbd_nextdata_n = nextdata_n_reg;
  assign key_valid          = valid_reg;
  assign key_code           = code_reg;
  assign key_ext            = ext_reg;
  assign key_release        = rel_reg;
  assign key_repeat         = rpt_reg;
  assign key_ascii          = ascii_reg;
  assign key_held           = held_reg;
  assign press_count        = count_reg;
  assign err_overflow       = err_reg;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// ---------------------------------------------------------------------------
// tb_ps2_key_decoder
//   Directed bench: a receiver FIFO model feeds scancode bytes; a monitor logs
//   every key event; each test task checks the logged events against
//   hand-computed values. A second instance with uppercase letters shares
//   the same byte stream.
// ---------------------------------------------------------------------------
module tb_ps2_key_decoder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ps2_key_decoder_if kif ();
  ps2_key_decoder_if kif_u ();

  assign kif_u.kbd_data     = kif.kbd_data;
  assign kif_u.kbd_ready    = kif.kbd_ready;
  assign kif_u.kbd_overflow = kif.kbd_overflow;

  logic       key_valid, key_ext, key_release, key_repeat, key_held, err_overflow;
  logic [7:0] key_code, key_ascii, press_count;
  logic       u_valid, u_ext, u_release, u_repeat, u_held, u_err;
  logic [7:0] u_code, u_ascii, u_count;

  ps2_key_decoder #(.ASCII_UPPER(1'b0), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .kbd(kif.slave),
    .key_valid(key_valid), .key_code(key_code), .key_ext(key_ext),
    .key_release(key_release), .key_repeat(key_repeat), .key_ascii(key_ascii),
    .key_held(key_held), .press_count(press_count), .err_overflow(err_overflow)
  );

  ps2_key_decoder #(.ASCII_UPPER(1'b1), .CNT_W(8)) dut_u (
    .clk(clk), .rst(rst), .kbd(kif_u.slave),
    .key_valid(u_valid), .key_code(u_code), .key_ext(u_ext),
    .key_release(u_release), .key_repeat(u_repeat), .key_ascii(u_ascii),
    .key_held(u_held), .press_count(u_count), .err_overflow(u_err)
  );

  // Receiver FIFO model: pops on a posedge where nextdata_n is low.
  logic [7:0] fifo_mem [0:4095];
  int head = 0;
  int tail = 0;

  initial begin
    kif.kbd_data     = 8'h00;
    kif.kbd_ready    = 1'b0;
    kif.kbd_overflow = 1'b0;
  end

  always @(posedge clk) begin
    int h;
    h = head;
    if (!kif.kbd_nextdata_n && (h != tail)) h = h + 1;
    head          <= h;
    kif.kbd_ready <= (h != tail);
    kif.kbd_data  <= fifo_mem[h[11:0]];
  end

  // Event monitor
  logic [7:0] ev_code    [0:511];
  logic       ev_ext     [0:511];
  logic       ev_rel     [0:511];
  logic       ev_rep     [0:511];
  logic [7:0] ev_ascii   [0:511];
  logic [7:0] ev_ascii_u [0:511];
  logic       ev_held    [0:511];
  logic [7:0] ev_cnt     [0:511];
  int ev_n     = 0;
  int pop_cnt  = 0;
  int dbl_low  = 0;
  bit prev_low = 1'b0;

  always @(negedge clk) begin
    if (key_valid && ev_n < 512) begin
      ev_code[ev_n]    <= key_code;
      ev_ext[ev_n]     <= key_ext;
      ev_rel[ev_n]     <= key_release;
      ev_rep[ev_n]     <= key_repeat;
      ev_ascii[ev_n]   <= key_ascii;
      ev_ascii_u[ev_n] <= u_ascii;
      ev_held[ev_n]    <= key_held;
      ev_cnt[ev_n]     <= press_count;
      ev_n             <= ev_n + 1;
    end
    if (!kif.kbd_nextdata_n) begin
      pop_cnt <= pop_cnt + 1;
      if (prev_low) dbl_low <= dbl_low + 1;
    end
    prev_low <= !kif.kbd_nextdata_n;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic push(input logic [7:0] b);
    fifo_mem[tail[11:0]] = b;
    tail = tail + 1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((head != tail) && (n < 3000)) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
    n_checks++;
    if (head != tail) begin
      n_fail++;
      $display("FAIL drain_timeout: head=%0d required tail=%0d", head, tail);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({key_valid, key_ext, key_release, key_repeat, key_held, err_overflow} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b required 000000",
               {key_valid, key_ext, key_release, key_repeat, key_held, err_overflow});
    end
    n_checks++;
    if ({key_code, key_ascii, press_count} !== 24'h0) begin
      n_fail++;
      $display("FAIL reset_fields: got %h required 000000", {key_code, key_ascii, press_count});
    end
    n_checks++;
    if (kif.kbd_nextdata_n !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_nextdata: got %b required 1", kif.kbd_nextdata_n);
    end
    rst = 1'b0;
    @(negedge clk);
    $display("reset released");
  endtask

  task automatic test_make_break();
    int b, p0;
    b = ev_n; p0 = pop_cnt;
    push(8'h1C); push(8'hF0); push(8'h1C);
    drain();
    $display("make_break: %0d events, %0d pops", ev_n - b, pop_cnt - p0);
    n_checks++;
    if (ev_n - b !== 2) begin
      n_fail++; $display("FAIL mb_event_count: got %0d required 2", ev_n - b);
    end
    n_checks++;
    if ({ev_code[b], ev_ascii[b], ev_rel[b], ev_rep[b], ev_held[b], ev_cnt[b]} !==
        {8'h1C, 8'h61, 1'b0, 1'b0, 1'b1, 8'd1}) begin
      n_fail++;
      $display("FAIL mb_make: got code=%h ascii=%h rel=%b rep=%b held=%b cnt=%0d required 1c 61 0 0 1 1",
               ev_code[b], ev_ascii[b], ev_rel[b], ev_rep[b], ev_held[b], ev_cnt[b]);
    end
    n_checks++;
    if ({ev_code[b+1], ev_rel[b+1], ev_rep[b+1], ev_held[b+1], ev_cnt[b+1]} !==
        {8'h1C, 1'b1, 1'b0, 1'b0, 8'd1}) begin
      n_fail++;
      $display("FAIL mb_break: got code=%h rel=%b rep=%b held=%b cnt=%0d required 1c 1 0 0 1",
               ev_code[b+1], ev_rel[b+1], ev_rep[b+1], ev_held[b+1], ev_cnt[b+1]);
    end
    n_checks++;
    if ((pop_cnt - p0 !== 3) || (dbl_low !== 0)) begin
      n_fail++;
      $display("FAIL mb_pops: got pops=%0d double_low=%0d required 3 and 0", pop_cnt - p0, dbl_low);
    end
  endtask

  task automatic test_repeat();
    int b;
    logic [7:0] c0;
    b = ev_n; c0 = press_count;
    push(8'h1B); push(8'h1B); push(8'h1B); push(8'hF0); push(8'h1B);
    drain();
    $display("repeat: %0d events, press_count=%0d", ev_n - b, press_count);
    n_checks++;
    if (ev_n - b !== 4) begin
      n_fail++; $display("FAIL rep_event_count: got %0d required 4", ev_n - b);
    end
    n_checks++;
    if ({ev_rep[b], ev_rep[b+1], ev_rep[b+2], ev_rel[b+2], ev_rel[b+3]} !== 5'b01101) begin
      n_fail++;
      $display("FAIL rep_flags: got %b required 01101",
               {ev_rep[b], ev_rep[b+1], ev_rep[b+2], ev_rel[b+2], ev_rel[b+3]});
    end
    n_checks++;
    if (press_count !== c0 + 8'd1) begin
      n_fail++; $display("FAIL rep_count: got %0d required %0d", press_count, c0 + 8'd1);
    end
    n_checks++;
    if ({ev_ascii[b], ev_ascii_u[b]} !== 16'h7353) begin
      n_fail++;
      $display("FAIL rep_ascii: got lower=%h upper=%h required 73 53", ev_ascii[b], ev_ascii_u[b]);
    end
  endtask

  task automatic test_ext();
    int b;
    b = ev_n;
    push(8'hE0); push(8'h75); push(8'hE0); push(8'hF0); push(8'h75);
    drain();
    $display("ext: %0d events", ev_n - b);
    n_checks++;
    if (ev_n - b !== 2) begin
      n_fail++; $display("FAIL ext_event_count: got %0d required 2", ev_n - b);
    end
    n_checks++;
    if ({ev_code[b], ev_ext[b], ev_ascii[b], ev_rel[b], ev_held[b]} !==
        {8'h75, 1'b1, 8'h00, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL ext_make: got code=%h ext=%b ascii=%h rel=%b held=%b required 75 1 00 0 1",
               ev_code[b], ev_ext[b], ev_ascii[b], ev_rel[b], ev_held[b]);
    end
    n_checks++;
    if ({ev_code[b+1], ev_ext[b+1], ev_rel[b+1], key_held} !== {8'h75, 1'b1, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL ext_break: got code=%h ext=%b rel=%b held=%b required 75 1 1 0",
               ev_code[b+1], ev_ext[b+1], ev_rel[b+1], key_held);
    end
  endtask

  task automatic test_rollover();
    int b;
    logic [7:0] c0;
    b = ev_n; c0 = press_count;
    push(8'h1C); push(8'h32); push(8'hF0); push(8'h1C);
    drain();
    $display("rollover: %0d events, press_count=%0d held=%b", ev_n - b, press_count, key_held);
    n_checks++;
    if ({ev_code[b+1], ev_rep[b+1], ev_ascii[b+1]} !== {8'h32, 1'b0, 8'h62}) begin
      n_fail++;
      $display("FAIL roll_second_make: got code=%h rep=%b ascii=%h required 32 0 62",
               ev_code[b+1], ev_rep[b+1], ev_ascii[b+1]);
    end
    n_checks++;
    if (press_count !== c0 + 8'd2) begin
      n_fail++; $display("FAIL roll_count: got %0d required %0d", press_count, c0 + 8'd2);
    end
    n_checks++;
    if ({ev_rel[b+2], key_held} !== 2'b11) begin
      n_fail++; $display("FAIL roll_break_held: got rel=%b held=%b required 1 1", ev_rel[b+2], key_held);
    end
  endtask

  task automatic test_wrap();
    int b;
    do_reset();
    for (int i = 0; i < 255; i++) push((i % 2 == 0) ? 8'h1C : 8'h32);
    drain();
    $display("wrap: press_count=%0d after 255 presses", press_count);
    n_checks++;
    if (press_count !== 8'hFF) begin
      n_fail++; $display("FAIL wrap_full: got %0d required 255", press_count);
    end
    b = ev_n;
    push(8'h32);
    drain();
    $display("wrap: press_count=%0d after one more", press_count);
    n_checks++;
    if ({press_count, ev_rep[b]} !== {8'h00, 1'b0}) begin
      n_fail++; $display("FAIL wrap_zero: got cnt=%0d rep=%b required 0 0", press_count, ev_rep[b]);
    end
  endtask

  task automatic test_overflow();
    int b;
    n_checks++;
    if (err_overflow !== 1'b0) begin
      n_fail++; $display("FAIL ovf_before: got %b required 0", err_overflow);
    end
    kif.kbd_overflow = 1'b1;
    @(negedge clk);
    kif.kbd_overflow = 1'b0;
    n_checks++;
    if (err_overflow !== 1'b1) begin
      n_fail++; $display("FAIL ovf_set: got %b required 1", err_overflow);
    end
    b = ev_n;
    push(8'h45);
    drain();
    $display("overflow: err_overflow=%b, event ascii=%h", err_overflow, ev_ascii[b]);
    n_checks++;
    if ({err_overflow, ev_n - b == 1, ev_ascii[b], press_count} !== {1'b1, 1'b1, 8'h30, 8'd1}) begin
      n_fail++;
      $display("FAIL ovf_sticky: got err=%b events=%0d ascii=%h cnt=%0d required 1 1 30 1",
               err_overflow, ev_n - b, ev_ascii[b], press_count);
    end
  endtask

  task automatic test_reset_mid();
    int b;
    b = ev_n;
    push(8'hF0);
    drain();
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if ({key_valid, key_ext, key_release, key_repeat, key_held, err_overflow,
         key_code, key_ascii, press_count, kif.kbd_nextdata_n} !== {6'b0, 24'h0, 1'b1}) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: got held=%b err=%b code=%h cnt=%0d nd_n=%b required 0 0 00 0 1",
               key_held, err_overflow, key_code, press_count, kif.kbd_nextdata_n);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    push(8'h1C);
    drain();
    $display("reset_mid: %0d events, rel=%b", ev_n - b, ev_rel[b]);
    n_checks++;
    if ({ev_n - b == 1, ev_rel[b], ev_code[b], key_held, press_count} !==
        {1'b1, 1'b0, 8'h1C, 1'b1, 8'd1}) begin
      n_fail++;
      $display("FAIL mid_after_make: got events=%0d rel=%b code=%h held=%b cnt=%0d required 1 0 1c 1 1",
               ev_n - b, ev_rel[b], ev_code[b], key_held, press_count);
    end
  endtask

  initial begin
    test_reset();
    test_make_break();
    test_repeat();
    test_ext();
    test_rollover();
    test_wrap();
    test_overflow();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_key_decoder.md
Name: ps2_key_decoder

Overview:
- Downstream consumer of the ps2_keyboard receiver FIFO: pops bytes via the ready/nextdata_n handshake and decodes PS/2 set-2 scancode streams (make, F0 break, E0 extended) into single-cycle key events.
- Each event carries code, ASCII, press/release and typematic-repeat flags, plus a distinct-press counter.
- Sits between the keyboard receiver and display/CPU-visible logic.

Parameters:
- ASCII_UPPER, 0, 1 = letters map to uppercase ASCII (0x41..), 0 = lowercase (0x61..).
- CNT_W, 8, width of press_count.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  asynchronous active-high reset.
- kbd_data  in  8  byte at receiver FIFO head, valid while kbd_ready=1.
- kbd_ready  in  1  receiver FIFO non-empty.
- kbd_overflow  in  1  receiver FIFO overflow flag.
- kbd_nextdata_n  out  1  active-low pop strobe to receiver, registered.
- key_valid  out  1  one-cycle pulse: key event fields valid.
- key_code  out  8  scancode of the event (F0/E0 prefixes stripped).
- key_ext  out  1  event was E0-prefixed.
- key_release  out  1  1 = break event, 0 = make event.
- key_repeat  out  1  make event is a typematic repeat of the held key.
- key_ascii  out  8  ASCII of key_code; 0x00 if unmapped or key_ext=1.
- key_held  out  1  a key is currently held (level).
- press_count  out  CNT_W  count of distinct new presses, wraps.
- err_overflow  out  1  sticky, set when kbd_overflow=1 is seen.

Behaviour:
- Reset (async, rst=1): kbd_nextdata_n=1; key_valid, key_ext, key_release, key_repeat, key_held, err_overflow=0; key_code, key_ascii, press_count=0; held-code register=0; pending flags cleared; FSM to IDLE. Reset mid-pop abandons the byte (not re-read unless still in FIFO).
- Pop FSM:
  - IDLE: if kbd_ready=1 at posedge, latch kbd_data into byte_r, drive kbd_nextdata_n<=0, go ACK.
  - ACK: kbd_nextdata_n<=1, process byte_r (below), go SETTLE.
  - SETTLE: one wait cycle so the receiver's ready/data reflect the popped pointer, then IDLE.
  - Exactly one byte per pop; nextdata_n low for exactly 1 cycle; minimum 3 cycles per byte.
- Decode (in ACK, byte_r):
  - 0xE0: ext_pend<=1, no event.
  - 0xF0: brk_pend<=1, no event.
  - Otherwise an event, with key_valid=1 in the following cycle, key_code=byte_r, key_ext=ext_pend. Both pending flags are then cleared.
    - Break (brk_pend=1): key_release=1, key_repeat=0. If {ext,code} equals the held register, key_held<=0; a break of a non-held key leaves key_held unchanged.
    - Make, same {ext,code} as held and key_held=1: key_repeat=1, press_count unchanged.
    - Make, otherwise: key_repeat=0, held register<={ext,code}, key_held<=1, press_count<=press_count+1 (wraps all-ones to 0).
- Event field timing: fields hold their value until the next event; key_valid is a 1-cycle pulse.
- Prefix order: F0 then E0, or E0 then F0, both accepted; repeated prefixes are idempotent.
- ASCII (key_ext=0 only; unmapped codes give 0x00):
  - Letters: 1C a, 32 b, 21 c, 23 d, 24 e, 2B f, 34 g, 33 h, 43 i, 3B j, 42 k, 4B l, 3A m, 31 n, 44 o, 4D p, 15 q, 2D r, 1B s, 2C t, 3C u, 2A v, 1D w, 22 x, 35 y, 1A z (case per ASCII_UPPER).
  - Digits: 45 '0', 16 '1', 1E '2', 26 '3', 25 '4', 2E '5', 36 '6', 3D '7', 3E '8', 46 '9'.
  - Others: 29→0x20, 5A→0x0D, 66→0x08.
  - ASCII is also reported on break events.
- err_overflow: set on any cycle with kbd_overflow=1; cleared only by rst. Decoding continues.
- kbd_ready dropping while in ACK/SETTLE: no effect.

Test Plan:
- Drive bytes 1C, F0, 1C through a receiver model → 2 events: make {code=1C, ascii=0x61, release=0, repeat=0}, then break {code=1C, release=1}; press_count=1; key_held 1 then 0; kbd_nextdata_n low for exactly 3 single cycles.
- Drive 1B, 1B, 1B, F0, 1B → makes with repeat=0,1,1, then a break; press_count increments by 1 only; ascii=0x73 (0x53 with ASCII_UPPER=1).
- Drive E0, 75, E0, F0, 75 → make {code=75, ext=1, ascii=0x00}, break {ext=1, release=1}; key_held cleared.
- Drive 1C, 32 (no break), then F0, 1C → second make has repeat=0 and moves held to 32; press_count+2; break of 1C leaves key_held=1.
- Preload press_count to all-ones via 2^CNT_W-1 distinct presses, then one more → wraps to 0. Pulse kbd_overflow one cycle → err_overflow=1 and stays set.
- Assert rst between F0 and 1C → all outputs 0, kbd_nextdata_n=1; subsequent 1C is decoded as a make, not a break.
